// File: rtl/ysyx_23060124_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// ysyx_23060124_axi_sram_slave
//
// AXI4-Lite responder backed by a word-addressed SRAM model. The read and
// write channels run separate IDLE -> WAIT -> RESP state machines. Each has
// a programmable response latency so that a master can be tested against
// slow memory.
//
// Ports
//   clk, i_rst          : rising-edge clock, asynchronous active-high reset
//   S_AXI_AR*           : read address channel   (ARADDR, ARVALID, ARREADY)
//   S_AXI_R*            : read data channel      (RDATA, RRESP, RVALID, RREADY)
//   S_AXI_AW*           : write address channel  (AWADDR, AWVALID, AWREADY)
//   S_AXI_W*            : write data channel     (WDATA, WSTRB, WVALID, WREADY)
//   S_AXI_B*            : write response channel (BRESP, BVALID, BREADY)
//
// Every output is driven directly from a register, so no path runs
// combinationally from an input to an output. Addresses outside
// [BASE_ADDR, BASE_ADDR + 4*2^MEM_DEPTH_LOG2) get SLVERR and never touch
// the SRAM. The SRAM contents are not reset.
// ---------------------------------------------------------------------------
module ysyx_23060124_axi_sram_slave #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    MEM_DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000,
    parameter int                    RD_LATENCY     = 2,
    parameter int                    WR_LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      i_rst,

    input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,

    input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY
);

    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int IDX_W     = MEM_DEPTH_LOG2;
    localparam int CNT_W     = 8;

    localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] WR_LAT_C = CNT_W'(WR_LATENCY);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // SRAM array
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // -----------------------------------------------------------------------
    // Read channel registers
    // -----------------------------------------------------------------------
    state_t                rd_state_reg, rd_state_next;
    logic [CNT_W-1:0]      rd_cnt_reg,   rd_cnt_next;
    logic [ADDR_WIDTH-1:0] rd_addr_reg,  rd_addr_next;
    logic                  arready_reg,  arready_next;
    logic                  rvalid_reg,   rvalid_next;
    logic [DATA_WIDTH-1:0] rdata_reg,    rdata_next;
    logic [1:0]            rresp_reg,    rresp_next;

    // -----------------------------------------------------------------------
    // Write channel registers
    // -----------------------------------------------------------------------
    state_t                wr_state_reg, wr_state_next;
    logic [CNT_W-1:0]      wr_cnt_reg,   wr_cnt_next;
    logic                  aw_done_reg,  aw_done_next;
    logic                  w_done_reg,   w_done_next;
    logic [ADDR_WIDTH-1:0] wr_addr_reg,  wr_addr_next;
    logic [DATA_WIDTH-1:0] wr_data_reg,  wr_data_next;
    logic [STRB_W-1:0]     wr_strb_reg,  wr_strb_next;
    logic                  awready_reg,  awready_next;
    logic                  wready_reg,   wready_next;
    logic                  bvalid_reg,   bvalid_next;
    logic [1:0]            bresp_reg,    bresp_next;

    // -----------------------------------------------------------------------
    // Address decode. The offset upper bits must all be zero and the address
    // must not sit below the base (that would wrap the subtraction around).
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] rd_off, wr_off;
    logic                  rd_in_range, wr_in_range;
    logic [IDX_W-1:0]      rd_idx, wr_idx;

    assign rd_off      = rd_addr_reg - BASE_ADDR;
    assign wr_off      = wr_addr_reg - BASE_ADDR;
    assign rd_in_range = (rd_addr_reg >= BASE_ADDR) && (rd_off[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign wr_in_range = (wr_addr_reg >= BASE_ADDR) && (wr_off[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign rd_idx      = rd_off[IDX_W+1:2];
    assign wr_idx      = wr_off[IDX_W+1:2];

    // The byte-lane bits are ignored, because the master pre-aligns and
    // uses strobes.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, rd_off[1:0], wr_off[1:0]};

    // Handshake strobes
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    assign ar_hs = S_AXI_ARVALID & arready_reg;
    assign r_hs  = rvalid_reg & S_AXI_RREADY;
    assign aw_hs = S_AXI_AWVALID & awready_reg;
    assign w_hs  = S_AXI_WVALID & wready_reg;
    assign b_hs  = bvalid_reg & S_AXI_BREADY;

    // The write lands on the same edge that raises BVALID.
    logic wr_fire, wr_commit;
    assign wr_fire   = (wr_state_reg == ST_WAIT) && (wr_cnt_reg == '0);
    assign wr_commit = wr_fire && wr_in_range;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            rd_state_reg <= ST_IDLE;
            rd_cnt_reg   <= '0;
            rd_addr_reg  <= '0;
            arready_reg  <= 1'b1;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= RESP_OKAY;
            wr_state_reg <= ST_IDLE;
            wr_cnt_reg   <= '0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            wr_strb_reg  <= '0;
            awready_reg  <= 1'b1;
            wready_reg   <= 1'b1;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            rd_state_reg <= rd_state_next;
            rd_cnt_reg   <= rd_cnt_next;
            rd_addr_reg  <= rd_addr_next;
            arready_reg  <= arready_next;
            rvalid_reg   <= rvalid_next;
            rdata_reg    <= rdata_next;
            rresp_reg    <= rresp_next;
            wr_state_reg <= wr_state_next;
            wr_cnt_reg   <= wr_cnt_next;
            aw_done_reg  <= aw_done_next;
            w_done_reg   <= w_done_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            wr_strb_reg  <= wr_strb_next;
            awready_reg  <= awready_next;
            wready_reg   <= wready_next;
            bvalid_reg   <= bvalid_next;
            bresp_reg    <= bresp_next;
        end
    end

    // -----------------------------------------------------------------------
    // Read FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            ST_IDLE: if (ar_hs)              rd_state_next = ST_WAIT;
            ST_WAIT: if (rd_cnt_reg == '0)   rd_state_next = ST_RESP;
            ST_RESP: if (r_hs)               rd_state_next = ST_IDLE;
            default:                         rd_state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Read FSM: outputs and datapath. The SRAM is sampled on the RVALID edge.
    // A write that commits on that same edge is therefore not yet visible.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_cnt_next  = rd_cnt_reg;
        rd_addr_next = rd_addr_reg;
        arready_next = arready_reg;
        rvalid_next  = rvalid_reg;
        rdata_next   = rdata_reg;
        rresp_next   = rresp_reg;
        case (rd_state_reg)
            ST_IDLE: begin
                if (ar_hs) begin
                    rd_addr_next = S_AXI_ARADDR;
                    arready_next = 1'b0;
                    rd_cnt_next  = RD_LAT_C;
                end
            end
            ST_WAIT: begin
                if (rd_cnt_reg == '0) begin
                    rvalid_next = 1'b1;
                    rdata_next  = rd_in_range ? mem[rd_idx] : '0;
                    rresp_next  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    rd_cnt_next = rd_cnt_reg - 1'b1;
                end
            end
            ST_RESP: begin
                if (r_hs) begin
                    rvalid_next  = 1'b0;
                    arready_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Write FSM: next state. AW and W may arrive in either order.
    // The FSM leaves IDLE once both are held, whether registered earlier or
    // arriving in this cycle.
    // -----------------------------------------------------------------------
    logic aw_have, w_have;
    assign aw_have = aw_done_reg | aw_hs;
    assign w_have  = w_done_reg  | w_hs;

    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            ST_IDLE: if (aw_have && w_have) wr_state_next = ST_WAIT;
            ST_WAIT: if (wr_cnt_reg == '0)  wr_state_next = ST_RESP;
            ST_RESP: if (b_hs)              wr_state_next = ST_IDLE;
            default:                        wr_state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Write FSM: outputs and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        wr_cnt_next  = wr_cnt_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        wr_strb_next = wr_strb_reg;
        awready_next = awready_reg;
        wready_next  = wready_reg;
        bvalid_next  = bvalid_reg;
        bresp_next   = bresp_reg;
        case (wr_state_reg)
            ST_IDLE: begin
                if (aw_hs) begin
                    wr_addr_next = S_AXI_AWADDR;
                    awready_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (w_hs) begin
                    wr_data_next = S_AXI_WDATA;
                    wr_strb_next = S_AXI_WSTRB;
                    wready_next  = 1'b0;
                    w_done_next  = 1'b1;
                end
                if (aw_have && w_have) begin
                    wr_cnt_next  = WR_LAT_C;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (wr_fire) begin
                    bvalid_next = 1'b1;
                    bresp_next  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    wr_cnt_next = wr_cnt_reg - 1'b1;
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    bvalid_next  = 1'b0;
                    awready_next = 1'b1;
                    wready_next  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // SRAM write port with per-byte enables. Reset leaves the FSM outside
    // WAIT, so a write that was not yet committed is never applied.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb_reg[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data_reg[8*b +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output drive
    // -----------------------------------------------------------------------
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = wready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;

endmodule

// File: tb/tb_ysyx_23060124_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// Directed testbench for ysyx_23060124_axi_sram_slave (default parameters:
// RD_LATENCY=2, WR_LATENCY=1, BASE 0x8000_0000, 4096 words).
// Inputs are driven 1 ns after the rising edge.
// Outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_ysyx_23060124_axi_sram_slave;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_23060124_axi_sram_slave dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full write: AW and W are issued in the same cycle.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        int k;
        chk("wr_ready_idle", {30'd0, awready, wready}, 32'd3);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_ready_drop", {30'd0, awready, wready}, 32'd0);
        k = 0;
        while (!bvalid && k < 50) begin
            step();
            k++;
        end
        chk("b_latency", 32'(k), 32'(1 + WR_LAT));
        chk("bresp", {30'd0, bresp}, {30'd0, exp_resp});
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bvalid_clear", {31'd0, bvalid}, 32'd0);
        chk("wr_ready_back", {30'd0, awready, wready}, 32'd3);
        $display("write addr=%h data=%h strb=%b bresp=%b lat=%0d", addr, data, strb, bresp, k);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        int k;
        chk("arready_idle", {31'd0, arready}, 32'd1);
        araddr = addr; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("arready_drop", {31'd0, arready}, 32'd0);
        k = 0;
        while (!rvalid && k < 50) begin
            step();
            k++;
        end
        chk("r_latency", 32'(k), 32'(1 + RD_LAT));
        chk("rdata", rdata, exp_data);
        chk("rresp", {30'd0, rresp}, {30'd0, exp_resp});
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("rvalid_clear", {31'd0, rvalid}, 32'd0);
        chk("arready_back", {31'd0, arready}, 32'd1);
        $display("read  addr=%h data=%h rresp=%b lat=%0d", addr, rdata, rresp, k);
    endtask

    initial begin
        int k;
        i_rst = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0;
        repeat (3) step();
        i_rst = 1'b0;
        step();

        // Reset state
        chk("rst_arready", {31'd0, arready}, 32'd1);
        chk("rst_awready", {31'd0, awready}, 32'd1);
        chk("rst_wready",  {31'd0, wready},  32'd1);
        chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst_rdata",   rdata, 32'd0);
        chk("rst_resp",    {28'd0, rresp, bresp}, 32'd0);
        $display("reset checked");

        // Write then read
        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 2'b00);
        axi_read (32'h8000_0010, 32'hDEAD_BEEF, 2'b00);

        // Byte strobes
        axi_write(32'h8000_0020, 32'h1122_3344, 4'b1111, 2'b00);
        axi_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00);
        axi_read (32'h8000_0020, 32'h11BB_33DD, 2'b00);
        axi_write(32'h8000_0020, 32'h5555_5555, 4'b0000, 2'b00);
        axi_read (32'h8000_0020, 32'h11BB_33DD, 2'b00);

        // W at T, AW at T+4
        wdata = 32'h0F0F_1234; wstrb = 4'b1111; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("skew_wready_low", {31'd0, wready}, 32'd0);
        chk("skew_awready_hi", {31'd0, awready}, 32'd1);
        repeat (3) begin
            step();
            chk("skew_wait", {30'd0, wready, bvalid}, 32'd0);
        end
        awaddr = 32'h8000_0030; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        k = 0;
        while (!bvalid && k < 50) begin
            step();
            k++;
        end
        chk("skew_b_latency", 32'(k), 32'(1 + WR_LAT));
        chk("skew_bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        $display("write addr=80000030 data=0f0f1234 (W 4 cycles before AW) lat=%0d", k);
        axi_read(32'h8000_0030, 32'h0F0F_1234, 2'b00);

        // Read backpressure: RREADY held low 10 cycles
        araddr = 32'h8000_0010; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 50) begin
            step();
            k++;
        end
        chk("bp_r_latency", 32'(k), 32'(1 + RD_LAT));
        repeat (10) begin
            step();
            chk("bp_rvalid", {31'd0, rvalid}, 32'd1);
            chk("bp_rdata", rdata, 32'hDEAD_BEEF);
            chk("bp_arready", {31'd0, arready}, 32'd0);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("bp_rvalid_clear", {31'd0, rvalid}, 32'd0);
        chk("bp_arready_back", {31'd0, arready}, 32'd1);
        $display("read  addr=80000010 with 10-cycle RREADY stall");

        // Write backpressure: BREADY held low 10 cycles
        awaddr = 32'h8000_0040; wdata = 32'h0000_00A5; wstrb = 4'b1111;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        k = 0;
        while (!bvalid && k < 50) begin
            step();
            k++;
        end
        chk("bp_b_latency", 32'(k), 32'(1 + WR_LAT));
        repeat (10) begin
            step();
            chk("bp_bvalid", {31'd0, bvalid}, 32'd1);
            chk("bp_wr_readys", {30'd0, awready, wready}, 32'd0);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bp_bvalid_clear", {31'd0, bvalid}, 32'd0);
        chk("bp_wr_readys_back", {30'd0, awready, wready}, 32'd3);
        $display("write addr=80000040 with 10-cycle BREADY stall");
        axi_read(32'h8000_0040, 32'h0000_00A5, 2'b00);

        // RREADY high before RVALID: one-cycle RVALID pulse at normal latency
        rready = 1'b1;
        araddr = 32'h8000_0030; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 50) begin
            step();
            k++;
        end
        chk("early_r_latency", 32'(k), 32'(1 + RD_LAT));
        chk("early_rdata", rdata, 32'h0F0F_1234);
        step();
        rready = 1'b0;
        chk("early_rvalid_pulse", {31'd0, rvalid}, 32'd0);
        chk("early_arready", {31'd0, arready}, 32'd1);
        $display("read  addr=80000030 with RREADY held early");

        // Out of range
        axi_read (32'h0000_1000, 32'h0, 2'b10);
        axi_read (32'h8000_4000, 32'h0, 2'b10);
        axi_write(32'h8000_0000, 32'h0BAD_F00D, 4'b1111, 2'b00);
        axi_write(32'h8000_3FFC, 32'hCAFE_F00D, 4'b1111, 2'b00);
        axi_write(32'h7FFF_FFFC, 32'h1234_5678, 4'b1111, 2'b10);
        axi_read (32'h8000_0000, 32'h0BAD_F00D, 2'b00);
        axi_read (32'h8000_3FFC, 32'hCAFE_F00D, 2'b00);
        axi_read (32'h8000_0010, 32'hDEAD_BEEF, 2'b00);

        // Reset in the middle of a read: no response may come out later
        araddr = 32'h8000_0010; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        step();
        i_rst = 1'b1;
        repeat (3) step();
        i_rst = 1'b0;
        step();
        chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("midrst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("midrst_readys", {29'd0, arready, awready, wready}, 32'd7);
        repeat (8) begin
            step();
            chk("midrst_no_rvalid", {31'd0, rvalid}, 32'd0);
        end
        $display("reset during read at addr=80000010");
        axi_read(32'h8000_0020, 32'h11BB_33DD, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060124_axi_sram_slave.md
Name: ysyx_23060124_axi_sram_slave

Overview:
AXI4-Lite responder backing the LSU/IFU AXI master ports with a word-addressed SRAM model. Read and write channels run independent state machines, each with a programmable response latency to emulate slow memory. Sits behind the EXU/LSU AXI master in the NPC simulation top; also the verification target for master-side handshake corner cases.

Parameters:
ADDR_WIDTH, 32, AXI address width (ARADDR/AWADDR)
DATA_WIDTH, 32, data width; fixed 32 (STRB = 4 bits)
MEM_DEPTH_LOG2, 12, SRAM depth = 2^MEM_DEPTH_LOG2 words
BASE_ADDR, 32'h8000_0000, byte address of word 0
RD_LATENCY, 2, cycles from AR handshake to RVALID, minus 1 (0 = RVALID the cycle after AR handshake)
WR_LATENCY, 1, cycles from AW+W both captured to BVALID, minus 1

Ports:
clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response (00 OKAY, 10 SLVERR)
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  4  byte enables, bit i -> WDATA[8i+7:8i]
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready

Behaviour:
- Reset (async, i_rst=1): ARREADY=AWREADY=WREADY=1; RVALID=BVALID=0; RDATA=0; RRESP=BRESP=00; counters 0; both FSMs IDLE. SRAM contents not reset. Any in-flight transaction is dropped; a write not yet committed never reaches SRAM.
- All outputs are registered; no combinational input->output paths.
- Address decode: in range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^MEM_DEPTH_LOG2; word index = (addr-BASE_ADDR)[MEM_DEPTH_LOG2+1:2]; addr[1:0] ignored (master pre-aligns, sends strobes).
- Read FSM IDLE -> WAIT -> RESP:
  - IDLE: ARREADY=1. On ARVALID&ARREADY (cycle T): latch addr, ARREADY<=0, cnt<=RD_LATENCY, go WAIT.
  - WAIT: cnt decrements per cycle; at cnt==0, RVALID<=1, RDATA<=mem[idx] (0 and RRESP=10 if out of range, else 00), go RESP. RVALID therefore rises at T+1+RD_LATENCY.
  - RESP: RVALID, RDATA, RRESP held stable until RREADY. On RVALID&RREADY (cycle U): RVALID<=0, ARREADY<=1 at U+1; back to IDLE. At most one outstanding read.
- Write FSM IDLE -> WAIT -> RESP:
  - IDLE: AW and W captured independently, either order or same cycle. AW handshake latches address and drops AWREADY; W handshake latches data/strobe and drops WREADY. When both captured (cycle C = later handshake): cnt<=WR_LATENCY, go WAIT.
  - WAIT: at cnt==0: commit write (bytes with STRB=1 updated; STRB=0000 updates nothing but still responds OKAY), BVALID<=1, BRESP=00 or 10 if out of range (no SRAM write); go RESP. BVALID rises at C+1+WR_LATENCY.
  - RESP: BVALID held until BREADY. On handshake: BVALID<=0, AWREADY<=WREADY<=1 next cycle, IDLE.
- Read/write concurrency: channels fully independent. If a read samples the same word on the same edge a write commits, the read returns pre-write data.
- RREADY/BREADY asserted before VALID: no effect; response still takes exactly the latency above. Handshake completes the same cycle VALID first rises.

Test Plan:
- Reset: hold i_rst=1 3 cycles mid-read -> RVALID=0, BVALID=0, all readys=1 the cycle after release; no RVALID ever emitted for the aborted read.
- Write then read, RD_LATENCY=2, WR_LATENCY=1: AW=8000_0010, W=DEADBEEF, STRB=1111 same cycle T -> BVALID at T+2, BRESP=00; AR=8000_0010 at cycle R -> RVALID at R+3, RDATA=DEADBEEF, RRESP=00.
- Byte strobe: word=11223344, write AABBCCDD STRB=0101 -> readback 11BB33DD; STRB=0000 -> unchanged, BRESP=00.
- AW/W skew: W at T, AW at T+4 -> WREADY low T+1..; BVALID at T+4+1+WR_LATENCY; data committed correctly.
- Backpressure: hold RREADY=0 10 cycles after RVALID -> RVALID, RDATA stable, ARREADY=0 throughout; RREADY=1 -> RVALID=0 and ARREADY=1 next cycle. Same for BREADY.
- Out of range: AR=0000_1000 -> RRESP=10, RDATA=0; AW=7FFF_FFFC write 12345678 -> BRESP=10, no SRAM word changes.
